// File: rtl/boa_peri_pwm_if.sv
// Peripheral bus between a bus master and memory-mapped slaves.
// addr is a word address; we is a byte-write mask; ready and rdata come from the slave.
interface boa_mem_bus;
  logic [29:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input addr, input we, input wdata, output rdata, output ready);
  modport CPU (output addr, output we, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_peri_pwm.sv
// Multi-channel PWM generator. One shared prescaler and period counter drive
// all channels. Period and duty values are double-buffered and copied to the
// active set at the end of each period, or continuously while disabled.
module boa_peri_pwm #(
  parameter logic [31:0] ADDR      = 32'h8000_0200,
  parameter int          CHANNELS  = 4,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  boa_mem_bus.MEM             bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] pwm_oe
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PERIOD = 4'h1;
  localparam logic [3:0] REG_COUNT  = 4'h2;
  localparam int         REG_DUTY0  = 4;

  // Programmer-visible state
  logic                r_en;
  logic [15:0]         r_presc;
  cnt_t                r_top_sh;
  cnt_t                r_duty_sh [CHANNELS];
  logic [CHANNELS-1:0] r_oe;
  logic [CHANNELS-1:0] r_inv;

  // Active (double-buffered) values and timing state
  cnt_t                r_top_act;
  cnt_t                r_duty_act [CHANNELS];
  logic [15:0]         r_pcnt;
  cnt_t                r_cnt;
  logic [CHANNELS-1:0] r_pwm_out;
  logic [31:0]         r_rdata;

  // Decode and next-shadow wires
  logic                w_sel;
  logic [3:0]          w_word;
  logic                w_wr;
  logic                w_ctrl_wr;
  logic                w_period_wr;
  logic [CHANNELS-1:0] w_duty_wr;
  cnt_t                w_top_nxt;
  cnt_t                w_duty_nxt [CHANNELS];
  logic                w_tick;
  logic                w_wrap;
  logic                w_reload;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // The 64-byte window is selected by byte address bits [31:6], i.e. word bits [29:4].
  assign w_sel       = (bus.addr[29:4] == ADDR[31:6]);
  assign w_word      = bus.addr[3:0];
  assign w_wr        = w_sel && (bus.we == 4'hF);
  assign w_ctrl_wr   = w_wr && (w_word == REG_CTRL);
  assign w_period_wr = w_wr && (w_word == REG_PERIOD);
  assign w_unused    = ^bus.wdata;

  assign bus.ready = 1'b1;
  assign bus.rdata = r_rdata;
  assign pwm_out   = r_pwm_out;
  assign pwm_oe    = r_oe;

  // Tick at prescaler terminal count; period end when the counter also sits at top.
  assign w_tick   = r_en && (r_pcnt == r_presc);
  assign w_wrap   = w_tick && (r_cnt == r_top_act);
  assign w_reload = !r_en || w_wrap;

  // Next shadow values, so a write coinciding with a reload is the value that gets loaded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_top_nxt = w_period_wr ? bus.wdata[CNT_WIDTH-1:0] : r_top_sh;
    w_duty_wr = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_duty_wr[n]  = w_wr && (w_word == 4'(REG_DUTY0 + n));
      w_duty_nxt[n] = w_duty_wr[n] ? bus.wdata[CNT_WIDTH-1:0] : r_duty_sh[n];
    end
  end

  // Register-file writes and shadow-to-active transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the small per-channel arrays are flops, not RAM, so they are reset like any other register.
      r_en      <= 1'b0;
      r_presc   <= '0;
      r_top_sh  <= '0;
      r_top_act <= '0;
      r_oe      <= '0;
      r_inv     <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_duty_sh[n]  <= '0;
        r_duty_act[n] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (w_ctrl_wr) begin
        r_en    <= bus.wdata[0];
        r_presc <= bus.wdata[31:16];
      end
      r_top_sh <= w_top_nxt;
      if (w_reload) r_top_act <= w_top_nxt;
      for (int n = 0; n < CHANNELS; n++) begin
        r_duty_sh[n] <= w_duty_nxt[n];
        if (w_reload) r_duty_act[n] <= w_duty_nxt[n];
        if (w_duty_wr[n]) begin
          r_oe[n]  <= bus.wdata[16];
          r_inv[n] <= bus.wdata[17];
        end
      end
    end
  end

  // Prescaler and period counter; both held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !r_en) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
    end else begin
      // A presc lowered below pcnt lets pcnt run on to its natural wrap without a tick.
      r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
      if (w_tick) r_cnt <= w_wrap ? cnt_t'(0) : r_cnt + cnt_t'(1);
    end
  end

  // Read mux for the registered read port.
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_word)
        REG_CTRL:   w_rdata = {r_presc, 15'd0, r_en};
        REG_PERIOD: w_rdata = 32'(r_top_sh);
        REG_COUNT:  w_rdata = 32'(r_cnt);
        default: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (w_word == 4'(REG_DUTY0 + n))
              w_rdata = {14'd0, r_inv[n], r_oe[n], 16'(r_duty_sh[n])};
          end
        end
      endcase
    end
  end

  // Registered PWM levels and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_out <= '0;
      r_rdata   <= '0;
    end else begin
      r_rdata <= w_rdata;
      for (int n = 0; n < CHANNELS; n++)
        r_pwm_out[n] <= r_en ? ((r_cnt < r_duty_act[n]) ^ r_inv[n]) : r_inv[n];
    end
  end

endmodule

// File: tb/tb_boa_peri_pwm.sv
// Directed bench for boa_peri_pwm: register access, waveform shape, double
// buffering, boundary duty values, ignored writes and mid-run reset.
module tb_boa_peri_pwm;

  localparam logic [31:0] BASE = 32'h8000_0200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pwm_out;
  logic [3:0] pwm_oe;
  int         n_tests = 0;
  int         n_fail  = 0;

  boa_mem_bus bus_if ();

  boa_peri_pwm dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .pwm_out (pwm_out),
    .pwm_oe  (pwm_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a write for one cycle; returns on the negedge after the write edge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    bus_if.addr  = 30'((BASE + 32'(off)) >> 2);
    bus_if.wdata = data;
    bus_if.we    = we;
    @(negedge clk);
    bus_if.we    = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] byte_addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.addr = 30'(byte_addr >> 2);
    bus_if.we   = 4'h0;
    @(negedge clk);
    data = bus_if.rdata;
  endtask

  // Wait (bounded) for a 0->1 transition of pwm_out[0], sampled on negedges.
  task automatic wait_rise(input string tag, input int budget);
    logic prev;
    logic found;
    prev  = pwm_out[0];
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) found = 1'b1;
      prev = pwm_out[0];
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Sample pwm_out[0] on consecutive negedges against a constant level.
  task automatic check_const(input string tag, input logic lvl, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check($sformatf("%s_%0d", tag, k), 32'(pwm_out[0]), 32'(lvl));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bus_if.addr  = '0;
    bus_if.we    = 4'h0;
    bus_if.wdata = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_pwm_out", 32'(pwm_out), 32'h0);
    check("rst_pwm_oe",  32'(pwm_oe),  32'h0);
    bus_read(BASE + 32'h00, rd); check("rst_ctrl",   rd, 32'h0);
    bus_read(BASE + 32'h04, rd); check("rst_period", rd, 32'h0);
    bus_read(BASE + 32'h08, rd); check("rst_count",  rd, 32'h0);
    bus_read(BASE + 32'h10, rd); check("rst_duty0",  rd, 32'h0);

    // presc=0, top=9, duty=3, oe: 3 high / 7 low, COUNT cycles 0..9
    bus_write(8'h04, 32'd9, 4'hF);
    bus_write(8'h10, 32'h0001_0003, 4'hF);
    bus_write(8'h00, 32'h0000_0001, 4'hF);
    check("t2_oe", 32'(pwm_oe), 32'h1);
    wait_rise("t2_rise", 40);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t2_pwm_%0d", i), 32'(pwm_out[0]), 32'((i % 10) < 3));
      if (i > 0) check($sformatf("t2_count_%0d", i), bus_if.rdata, 32'(i % 10));
      if (i == 0) bus_if.addr = 30'((BASE + 32'h08) >> 2);
    end

    // Mid-period duty change: current period keeps 3, next period uses 7
    wait_rise("t3_rise", 40);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t3_pwm_%0d", i), 32'(pwm_out[0]),
            32'((i < 10) ? (i < 3) : ((i - 10) < 7)));
      if (i == 1) begin
        bus_if.addr  = 30'((BASE + 32'h10) >> 2);
        bus_if.wdata = 32'h0001_0007;
        bus_if.we    = 4'hF;
      end
      if (i == 2) bus_if.we = 4'h0;
      if (i == 3) check("t3_duty_rb", bus_if.rdata, 32'h0001_0007);
    end

    // presc=3, top=4, duty=2: 20-clock period, 8 high
    bus_write(8'h00, 32'h0, 4'hF);
    bus_write(8'h04, 32'd4, 4'hF);
    bus_write(8'h10, 32'h0001_0002, 4'hF);
    bus_write(8'h00, 32'h0003_0001, 4'hF);
    wait_rise("t4_rise", 100);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t4_pwm_%0d", i), 32'(pwm_out[0]), 32'((i % 20) < 8));
    end
    bus_write(8'h10, 32'h0001_0000, 4'hF);   // duty 0 -> constant 0
    repeat (45) @(negedge clk);
    check_const("t4_duty0", 1'b0, 20);
    bus_write(8'h10, 32'h0001_0005, 4'hF);   // duty > top -> constant 1
    repeat (45) @(negedge clk);
    check_const("t4_duty5", 1'b1, 20);
    bus_write(8'h10, 32'h0003_0005, 4'hF);   // inverted -> constant 0
    repeat (45) @(negedge clk);
    check_const("t4_inv_duty5", 1'b0, 20);
    bus_write(8'h10, 32'h0003_0000, 4'hF);   // inverted duty 0 -> constant 1
    repeat (45) @(negedge clk);
    check_const("t4_inv_duty0", 1'b1, 20);

    // Ignored writes and unmapped reads
    bus_write(8'h04, 32'd7, 4'b0011);
    bus_read(BASE + 32'h04, rd); check("t5_partial_we", rd, 32'd4);
    bus_read(BASE + 32'h3C, rd); check("t5_rd_3c", rd, 32'h0);
    bus_read(BASE + 32'h20, rd); check("t5_rd_slot4", rd, 32'h0);
    bus_read(BASE + 32'h40, rd); check("t5_rd_outside", rd, 32'h0);
    bus_write(8'h00, 32'h0, 4'hF);
    bus_write(8'h08, 32'h55, 4'hF);
    bus_read(BASE + 32'h08, rd); check("t5_count_wr", rd, 32'h0);

    // top=0: output follows duty>=1
    bus_write(8'h04, 32'd0, 4'hF);
    bus_write(8'h10, 32'h0001_0001, 4'hF);
    bus_write(8'h00, 32'h0000_0001, 4'hF);
    repeat (5) @(negedge clk);
    check_const("t5_top0_d1", 1'b1, 10);
    bus_write(8'h10, 32'h0001_0000, 4'hF);
    repeat (5) @(negedge clk);
    check_const("t5_top0_d0", 1'b0, 10);

    // Reset mid-run
    bus_write(8'h04, 32'd9, 4'hF);
    bus_write(8'h10, 32'h0003_0000, 4'hF);
    repeat (25) @(negedge clk);
    check("t6_pre_out", 32'(pwm_out[0]), 32'h1);
    check("t6_pre_oe",  32'(pwm_oe[0]),  32'h1);
    rst         = 1'b1;
    bus_if.addr = 30'(BASE >> 2);
    @(negedge clk);
    check("t6_out",   32'(pwm_out), 32'h0);
    check("t6_oe",    32'(pwm_oe),  32'h0);
    check("t6_rdata", bus_if.rdata, 32'h0);
    rst = 1'b0;
    bus_read(BASE + 32'h08, rd); check("t6_count", rd, 32'h0);
    bus_read(BASE + 32'h00, rd); check("t6_ctrl",  rd, 32'h0);
    bus_read(BASE + 32'h10, rd); check("t6_duty0", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_peri_pwm.md
Name: boa_peri_pwm

Overview:
- Memory-mapped multi-channel PWM generator on the peripheral bus.
- Sits directly upstream of the GPIO matrix: its pwm_out/pwm_oe vectors drive that matrix's ext/ext_oe inputs, so any pin can be routed to any PWM channel.
- One shared prescaler and period counter for all channels; per-channel duty, invert and output-enable.
- Period and duty updates are double-buffered so each PWM period stays glitch-free.

Parameters:
- addr, 32'h8000_0200: byte base address; 64-byte window, aligned to 64.
- channels, 4: number of PWM channels, 1 to 8.
- cnt_width, 16: counter, period and duty width, 2 to 16.

Ports:
- clk  input  1: peripheral bus clock; the block's only clock.
- rst  input  1: reset, synchronous, active-high.
- bus  boa_mem_bus.MEM  -: peripheral bus interface; addr is a word address, we is the 4-bit byte-write mask.
- pwm_out  output  channels: PWM levels; connect to GPIO matrix ext.
- pwm_oe  output  channels: per-channel output enables; connect to GPIO matrix ext_oe.

Behaviour:
- Bus ready is tied to 1.
- rdata is registered and valid the cycle after addr is presented; it is 0 for unmapped addresses and during rst.
- Writes take effect only when we==15; any other nonzero we is ignored.
- Register map, byte offsets from addr:
  - 0x00 CTRL: [0] en; [31:16] presc.
  - 0x04 PERIOD: [cnt_width-1:0] top, shadow value.
  - 0x08 COUNT: read-only current counter; writes ignored.
  - 0x10+4n DUTY[n]: [cnt_width-1:0] duty shadow; [16] oe; [17] inv. Applies for n<channels; higher slots read 0.
  - Readback of PERIOD and DUTY returns the shadow value, not the active value.
- Reset: all registers, shadow and active values, prescaler and counter are 0; pwm_out=0; pwm_oe=0.
- Prescaler:
  - While en=1, pcnt increments every clk.
  - When pcnt==presc it wraps to 0 and asserts tick for one cycle.
  - presc=0 gives a tick every cycle.
- Counter:
  - On tick, cnt increments.
  - When cnt==top_act at a tick, cnt wraps to 0 and a reload occurs.
  - Period is (top_act+1)*(presc+1) clocks.
- Reload: top_act <= PERIOD shadow and duty_act[n] <= DUTY[n] shadow, all in the same cycle.
- Disabled (en=0):
  - pcnt and cnt are held at 0.
  - Active values continuously track the shadows.
  - pwm_out[n] = inv[n].
  - Setting en=1 starts counting from cnt=0 with the current shadows already active.
- Output: pwm_out[n] is registered: pwm_out[n] <= (cnt < duty_act[n]) ^ inv[n], using the cnt value of the same cycle, so it lags cnt by one clock.
  - duty_act=0 gives constant inv.
  - duty_act > top_act gives constant !inv.
- pwm_oe[n] = DUTY[n].oe, registered; it follows a write one clock after the write cycle, with no double-buffering.
- presc changes take effect immediately. If the new presc < pcnt, pcnt continues to its width maximum and wraps to 0; no tick is generated in that case.
- A shadow write in the same cycle as a reload: the newly written value is what gets loaded.
- top=0: cnt stays 0, a reload occurs every tick, and the output is high (inv=0) only if duty≥1.
- rst mid-operation: all state returns to reset values in the next cycle regardless of bus activity.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 and 0x10 -> all 0; pwm_out=0; pwm_oe=0.
- presc=0, top=9, DUTY0=3|oe, en=1 -> pwm_out[0] repeats 3 clocks high, 7 low; pwm_oe[0]=1; COUNT reads cycle 0..9.
- While running with top=9, duty=3, write DUTY0=7 mid-period -> current period still 3 high; next period 7 high; readback of 0x10 is 7 immediately.
- presc=3, top=4, duty=2 -> period 20 clocks, 8 high; duty=0 -> constant 0; duty=5 -> constant 1; with inv=1 each level is inverted.
- Write with we=4'b0011 to PERIOD -> value unchanged; read of 0x3C with channels=4 -> 0; write to COUNT -> ignored.
- Assert rst for 1 cycle while running -> next cycle pwm_out=0, pwm_oe=0, COUNT=0, en=0.
